// File: rtl/bit_field_pkg.sv
// ============================================================================
// Module   : bit_field_pkg
// Purpose  : Shared types, defaults and width clamp for bit_field_inserter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bit_field_pkg;

    localparam int WORD_W_DEFAULT  = 64;
    localparam int FIELD_W_DEFAULT = 16;

    typedef enum logic [7:0] {
        STATE_IDLE  = 8'd0,
        STATE_MERGE = 8'd1,
        STATE_EMIT  = 8'd2
    } state_t;

    // Requests wider than the field port are treated as full-width fields.
    function automatic logic [4:0] clamp_width(input logic [4:0] width);
        return (width > 5'(FIELD_W_DEFAULT)) ? 5'(FIELD_W_DEFAULT) : width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/field_mask_gen.sv
// ============================================================================
// Module   : field_mask_gen
// Purpose  : Combinational word mask and overflow flag for a (lsb, width) field.
// Revision : 1.0
// ============================================================================
`default_nettype none

module field_mask_gen #(
    parameter int WORD_W = 64
) (
    input  logic [$clog2(WORD_W)-1:0] i_lsb,
    input  logic [4:0]                i_width,
    output logic [WORD_W-1:0]         o_mask,
    output logic                      o_overflow
);

    localparam int SUM_W = $clog2(WORD_W) + 2;

    logic [WORD_W-1:0] w_ones;
    logic [SUM_W-1:0]  w_end;

    assign w_ones     = (WORD_W'(1) << i_width) - WORD_W'(1);
    // Bits shifted past the MSB fall off; they are reported, never wrapped.
    assign o_mask     = w_ones << i_lsb;
    assign w_end      = SUM_W'(i_lsb) + SUM_W'(i_width);
    assign o_overflow = (w_end > SUM_W'(WORD_W));

endmodule

`default_nettype wire

// File: rtl/bit_field_inserter.sv
// ============================================================================
// Module   : bit_field_inserter
// Purpose  : Read-modify-write packer of narrow fields into a word register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bit_field_inserter
    import bit_field_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEFAULT,
    parameter int FIELD_W = FIELD_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FIELD_W-1:0]        in_field,
    input  logic [$clog2(WORD_W)-1:0] in_lsb,
    input  logic [4:0]                in_width,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W-1:0]         out_word,
    output logic                      out_overflow
);

    localparam int LSB_W = $clog2(WORD_W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FIELD_W-1:0] r_field;
    logic [LSB_W-1:0]   r_lsb;
    logic [4:0]         r_width;
    logic               r_last;
    logic [WORD_W-1:0]  r_acc;
    logic               r_ovf;

    logic [WORD_W-1:0]  w_mask;
    logic               w_mask_ovf;
    logic [WORD_W-1:0]  w_data;
    logic               w_accept;
    logic               w_emit_done;

    field_mask_gen #(
        .WORD_W (WORD_W)
    ) u_mask (
        .i_lsb      (r_lsb),
        .i_width    (r_width),
        .o_mask     (w_mask),
        .o_overflow (w_mask_ovf)
    );

    assign w_data      = (WORD_W'(r_field) << r_lsb) & w_mask;
    assign w_accept    = in_valid && in_ready;
    assign w_emit_done = (r_state == STATE_EMIT) && out_ready;

    // Reset gates ready so nothing is accepted while the block is held clear.
    assign in_ready     = (r_state == STATE_IDLE) && !reset;
    assign out_valid    = (r_state == STATE_EMIT);
    assign out_word     = r_acc;
    assign out_overflow = r_ovf;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            STATE_IDLE:  if (w_accept) w_state_nxt = STATE_MERGE;
            STATE_MERGE: w_state_nxt = r_last ? STATE_EMIT : STATE_IDLE;
            STATE_EMIT:  if (out_ready) w_state_nxt = STATE_IDLE;
            default:     w_state_nxt = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_field <= '0;
            r_lsb   <= '0;
            r_width <= '0;
            r_last  <= 1'b0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_field <= in_field;
                r_lsb   <= in_lsb;
                r_width <= clamp_width(in_width);
                r_last  <= in_last;
            end
            if (r_state == STATE_MERGE) begin
                r_acc <= (r_acc & ~w_mask) | w_data;
                if (w_mask_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_emit_done) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bit_field_inserter.sv
// ============================================================================
// Module   : tb_bit_field_inserter
// Purpose  : Directed self-checking bench with a bit-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bit_field_inserter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_field = '0;
    logic [5:0]  in_lsb = '0;
    logic [4:0]  in_width = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_word;
    logic        out_overflow;

    int          n_checks = 0;
    int          n_fail = 0;

    // Reference model state: word being built and the word expected on output.
    logic [63:0] m_acc = '0;
    logic        m_ovf = 1'b0;
    logic [63:0] exp_word = '0;
    logic        exp_ovf = 1'b0;

    always #5 clk = ~clk;

    bit_field_inserter dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_field     (in_field),
        .in_lsb       (in_lsb),
        .in_width     (in_width),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .out_overflow (out_overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Deposit bit by bit; anything landing past bit 63 is dropped and flagged.
    task automatic model_apply(input logic [15:0] f, input int lsb, input int width);
        int w;
        w = (width > 16) ? 16 : width;
        for (int i = 0; i < w; i++) begin
            if (lsb + i < 64) m_acc[lsb + i] = f[i];
            else              m_ovf = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                check("stream_word", out_word, exp_word);
                check("stream_ovf", 64'(out_overflow), 64'(exp_ovf));
            end
            check("ready_valid_exclusive", 64'(in_ready && out_valid), 64'd0);
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // Accept in cycle N; returns at the negedge of N+2.
    task automatic send(input logic [15:0] f, input int lsb, input int width, input logic last);
        wait_ready();
        in_valid = 1'b1;
        in_field = f;
        in_lsb   = 6'(lsb);
        in_width = 5'(width);
        in_last  = last;
        @(posedge clk);
        model_apply(f, lsb, width);
        if (last) begin
            exp_word = m_acc;
            exp_ovf  = m_ovf;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("merge_in_ready", 64'(in_ready), 64'd0);
        check("merge_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        if (last) check("emit_out_valid", 64'(out_valid), 64'd1);
        else      check("idle_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic take_word();
        out_ready = 1'b1;
        @(posedge clk);
        m_acc = '0;
        m_ovf = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("taken_out_valid", 64'(out_valid), 64'd0);
        check("taken_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic expect_word(input string name, input logic [63:0] lit, input logic lit_ovf);
        check({name, "_dut"}, out_word, lit);
        check({name, "_model"}, exp_word, lit);
        check({name, "_ovf"}, 64'(out_overflow), 64'(lit_ovf));
    endtask

    initial begin
        logic [63:0] held;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_word", out_word, 64'd0);
        check("rst_out_ovf", 64'(out_overflow), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);

        send(16'h0012, 4, 16, 1'b1);
        expect_word("w1", 64'h0000_0000_0000_0120, 1'b0);
        take_word();

        send(16'h0456, 36, 16, 1'b1);
        expect_word("w2", 64'h0000_4560_0000_0000, 1'b0);
        held = out_word;
        check("w2_slice", 64'(held[51:36]), 64'h0456);
        take_word();

        send(16'hFFFF, 0, 16, 1'b0);
        send(16'h0000, 4, 4, 1'b1);
        expect_word("overlap", 64'h0000_0000_0000_FF0F, 1'b0);
        take_word();

        send(16'hFFFF, 8, 3, 1'b1);
        expect_word("width3", 64'h0000_0000_0000_0700, 1'b0);
        take_word();

        send(16'hABCD, 56, 16, 1'b1);
        expect_word("ovf", 64'hCD00_0000_0000_0000, 1'b1);
        take_word();
        send(16'h0001, 0, 1, 1'b1);
        expect_word("after_ovf", 64'h0000_0000_0000_0001, 1'b0);
        take_word();

        send(16'hFFFF, 0, 31, 1'b0);
        send(16'h1234, 20, 0, 1'b0);
        send(16'h000F, 60, 4, 1'b1);
        expect_word("clamp_w0_top", 64'hF000_0000_0000_FFFF, 1'b0);
        take_word();

        send(16'h00AA, 8, 8, 1'b1);
        expect_word("bp", 64'h0000_0000_0000_AA00, 1'b0);
        held     = out_word;
        in_valid = 1'b1;
        in_field = 16'h5555;
        in_lsb   = 6'd0;
        in_width = 5'd16;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_word", out_word, held);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        take_word();

        send(16'h00FF, 0, 8, 1'b0);
        in_valid = 1'b1;
        in_field = 16'h0F0F;
        in_lsb   = 6'd16;
        in_width = 5'd16;
        in_last  = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_word", out_word, 64'd0);
        m_acc = '0;
        m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(16'h0003, 2, 2, 1'b1);
        expect_word("after_arst", 64'h0000_0000_0000_000C, 1'b0);
        take_word();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/bit_field_inserter.md
# bit_field_inserter

Packs narrow bit fields into a 64-bit word by part-select write, the write-side counterpart to part-select extraction (for example, reading `val[19:4]`). A producer deposits up to 16 bits at any offset over successive handshakes. The block read-modify-writes its accumulator and presents the finished word downstream when a field is tagged last. It sits between a field-producing FSM and a word-wide consumer.

## Interface
Parameters:
- WORD_W, 64, accumulator width; LSB index width is $clog2(WORD_W)
- FIELD_W, 16, maximum field width

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  field request present
- in_ready  output  1  block can accept a field
- in_field  input  FIELD_W  field value, right-justified
- in_lsb  input  6  bit position of field LSB in the word
- in_width  input  5  field width in bits; 0 = no-op; values >16 are clamped to 16
- in_last  input  1  word complete after this field
- out_valid  output  1  finished word available
- out_ready  input  1  consumer accepts the word
- out_word  output  WORD_W  accumulated word
- out_overflow  output  1  some field bits fell above bit 63 during this word

## Operation
- States: IDLE, MERGE, EMIT. Reset sets the state to IDLE. Reset also clears the accumulator, the latched request, and the overflow flag to 0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch field, lsb, clamped width and last, then go to MERGE.
- MERGE:
  - in_ready=0.
  - Compute mask = ((1<<w)-1)<<lsb, truncated to 64 bits.
  - Update acc <= (acc & ~mask) | (((field & ((1<<w)-1)) << lsb) & mask). Bits outside the mask are preserved.
  - If lsb+w > 64, set the overflow flag; the excess bits are discarded, never wrapped.
  - If w=0, acc is unchanged and overflow is not set.
  - Next state: EMIT if last, else IDLE.
- EMIT:
  - out_valid=1 with out_word=acc and out_overflow=flag. Both are held stable until out_ready.
  - in_ready=0 throughout.
  - On out_valid&&out_ready: acc<=0, flag<=0, next state IDLE.
- out_word tracks acc continuously, but is meaningful only while out_valid=1.
- Overlapping fields: the later field wins on overlapping bits.

## Timing
- Reset values:
  - in_ready=0 while reset is asserted, then 1 on the first cycle after deassertion (IDLE).
  - out_valid=0, out_word=0, out_overflow=0.
- Field accepted in cycle N → acc updated at the end of N+1 → in_ready high again in N+2. Throughput is one field per 2 cycles.
- Last field accepted in cycle N → out_valid high in cycle N+2. Minimum word turnaround is accept(N), merge(N+1), emit(N+2), idle(N+3) when out_ready=1 in N+2.
- in_valid with in_ready=0 is ignored. The producer holds its request until a handshake occurs.
- out_ready without out_valid has no effect.
- The outputs carry no combinational path from in_* or out_ready. in_ready and out_valid are decoded from registered state only.
- Reset asserted in any state: the block enters IDLE asynchronously, and any in-flight field or pending word is lost.

## Structure
- Package bit_field_pkg holds:
  - state encoding constants STATE_IDLE=0, STATE_MERGE=1, STATE_EMIT=2 in an 8-bit state register
  - WORD_W and FIELD_W defaults
  - the clamp function for width
- Sub-module field_mask_gen is combinational. It takes (lsb, width) and returns the 64-bit mask plus the overflow bit, and is instantiated once.

## Test plan
- Reset release, then field 16'h0012 at lsb=4, width=16, last=1 → out_valid in cycle N+2, out_word=64'h0000_0000_0000_0120, out_overflow=0.
- Field 16'h0456 at lsb=36, width=16, last=1 → out_word=64'h0000_4560_0000_0000; out_word[51:36] reads back 16'h0456.
- Field 16'hFFFF at lsb=0, width=16, then field 16'h0000 at lsb=4, width=4, last=1 → out_word=64'h0000_0000_0000_FF0F. Also checks width masking: field 16'hFFFF at lsb=8, width=3 alone yields 64'h700.
- Overflow: field 16'hABCD at lsb=56, width=16, last=1 → out_word=64'hCD00_0000_0000_0000, out_overflow=1. The next word then starts from 0 with out_overflow=0.
- Backpressure: out_ready=0 for 5 cycles.
  - out_word and out_valid stay stable, and in_ready=0 throughout.
  - Asserting in_valid during this window does not change acc.
  - out_ready=1 → out_valid=0 in the next cycle.
- Async reset asserted mid-cycle while in MERGE with acc nonzero → in_ready=0, out_valid=0 and out_word=0 before the next clock edge. After deassertion, the first new field merges into a zero word.
